// File: rtl/a2d_rr_sched.sv
// Round-robin A2D sampler: each conversion is a two-word SPI exchange, left -> right -> battery.
// wrt one cycle after nxt; the SPI done handshake stalls the block, and a missing done times out.
module a2d_rr_sched #(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_BATT  = 3'd5,
    parameter int          TIMEOUT  = 1024,
    parameter logic [11:0] MIN_LOAD = 12'h200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld,
    output logic        busy,
    output logic        err,
    output logic        rider_present
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT1, S_GAP, S_READ, S_WAIT2} state_t;

    state_t      r_state, w_nxt_state;
    logic [1:0]  r_ptr;
    logic [TW-1:0] r_tmr;
    logic [15:0] r_cmd;
    logic [11:0] r_lft, r_rght, r_batt;
    logic        r_vld, r_err, r_rider;
    logic [2:0]  w_ch;
    logic        w_wait, w_tmo, w_fin;
    logic [12:0] w_sum;
    logic        w_unused;

    assign w_unused = ^rd_data[15:12];
    assign w_wait   = (r_state == S_WAIT1) || (r_state == S_WAIT2);
    assign w_tmo    = w_wait && !done && (r_tmr == TW'(TIMEOUT - 1));
    assign w_fin    = (r_state == S_WAIT2) && done;
    assign w_sum    = {1'b0, r_lft} + {1'b0, r_rght};

    // Pointer value 3 is unreachable; it falls back to the left channel.
    always_comb begin
        case (r_ptr)
            2'd1:    w_ch = CH_RGHT;
            2'd2:    w_ch = CH_BATT;
            default: w_ch = CH_LFT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:  if (nxt) w_nxt_state = S_CMD;
            S_CMD:   w_nxt_state = S_WAIT1;
            S_WAIT1: if (done) w_nxt_state = S_GAP;
                     else if (w_tmo) w_nxt_state = S_IDLE;
            S_GAP:   w_nxt_state = S_READ;
            S_READ:  w_nxt_state = S_WAIT2;
            S_WAIT2: if (done || w_tmo) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        wrt  = 1'b0;
        busy = 1'b0;
        if (r_state == S_CMD || r_state == S_READ) wrt = 1'b1;
        if (r_state != S_IDLE) busy = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 2'd0;
            r_tmr   <= '0;
            r_cmd   <= 16'h0000;
            r_lft   <= 12'h000;
            r_rght  <= 12'h000;
            r_batt  <= 12'h000;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
            r_rider <= 1'b0;
        end else begin
            r_vld   <= w_fin;
            r_err   <= w_tmo;
            r_rider <= (w_sum >= {1'b0, MIN_LOAD});
            // The word latched here is resent unchanged in READ.
            if (r_state == S_IDLE && nxt) r_cmd <= {2'b00, w_ch, 11'h000};
            if (r_state == S_CMD || r_state == S_READ) r_tmr <= '0;
            else if (w_wait)                           r_tmr <= r_tmr + TW'(1);
            if (w_fin) begin
                case (r_ptr)
                    2'd1:    r_rght <= rd_data[11:0];
                    2'd2:    r_batt <= rd_data[11:0];
                    default: r_lft  <= rd_data[11:0];
                endcase
            end
            // A timeout still advances, so a dead channel cannot starve the rest.
            if (w_fin || w_tmo) begin
                case (r_ptr)
                    2'd0:    r_ptr <= 2'd1;
                    2'd1:    r_ptr <= 2'd2;
                    default: r_ptr <= 2'd0;
                endcase
            end
        end
    end

    assign cmd           = r_cmd;
    assign lft_ld        = r_lft;
    assign rght_ld       = r_rght;
    assign batt          = r_batt;
    assign vld           = r_vld;
    assign err           = r_err;
    assign rider_present = r_rider;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Directed bench for a2d_rr_sched: round-robin order, result capture, rider flag, timeout, reset abort.
module tb_a2d_rr_sched;

    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        rst_n;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        vld, busy, err, rider_present;

    int n_chk  = 0;
    int n_fail = 0;

    a2d_rr_sched #(.TIMEOUT(TIMEOUT)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .nxt           (nxt),
        .wrt           (wrt),
        .cmd           (cmd),
        .done          (done),
        .rd_data       (rd_data),
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .batt          (batt),
        .vld           (vld),
        .busy          (busy),
        .err           (err),
        .rider_present (rider_present)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion; poke drives nxt while busy and together with the final done.
    task automatic conv(input logic [15:0] rdat, input logic [15:0] exp_cmd, input bit poke);
        int n_wrt;
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        chk("cmd_wrt", {15'd0, wrt}, 16'd1);
        chk("cmd_word", cmd, exp_cmd);
        tick();
        chk("wait1_wrt", {15'd0, wrt}, 16'd0);
        chk("wait1_busy", {15'd0, busy}, 16'd1);
        if (poke) nxt = 1'b1;
        tick();
        nxt = 1'b0;
        chk("wait1_hold", {15'd0, wrt}, 16'd0);
        done = 1'b1;
        rd_data = rdat;
        tick();
        done = 1'b0;
        chk("gap_wrt", {15'd0, wrt}, 16'd0);
        tick();
        chk("read_wrt", {15'd0, wrt}, 16'd1);
        chk("read_word", cmd, exp_cmd);
        tick();
        chk("wait2_vld", {15'd0, vld}, 16'd0);
        done = 1'b1;
        if (poke) nxt = 1'b1;
        tick();
        done = 1'b0;
        nxt = 1'b0;
        chk("fin_vld", {15'd0, vld}, 16'd1);
        chk("fin_busy", {15'd0, busy}, 16'd0);
        n_wrt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wrt) n_wrt++;
            if (i == 0) chk("vld_width", {15'd0, vld}, 16'd0);
        end
        chk("no_extra_wrt", 16'(n_wrt), 16'd0);
        chk("idle_busy", {15'd0, busy}, 16'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wrt"}, {15'd0, wrt}, 16'd0);
        chk({tag, "_cmd"}, cmd, 16'h0000);
        chk({tag, "_lft"}, {4'd0, lft_ld}, 16'h0000);
        chk({tag, "_rght"}, {4'd0, rght_ld}, 16'h0000);
        chk({tag, "_batt"}, {4'd0, batt}, 16'h0000);
        chk({tag, "_flags"}, {12'd0, vld, busy, err, rider_present}, 16'h0000);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        nxt = 1'b0;
        done = 1'b0;
        rd_data = 16'h0000;
        tick();
        tick();
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        conv(16'h0130, 16'h0000, 1'b0);
        chk("lft_ld", {4'd0, lft_ld}, 16'h0130);
        chk("rider_130", {15'd0, rider_present}, 16'd0);
        conv(16'h00FF, 16'h2000, 1'b0);
        chk("rght_ld", {4'd0, rght_ld}, 16'h00FF);
        conv(16'hFABC, 16'h2800, 1'b0);
        chk("batt", {4'd0, batt}, 16'h0ABC);
        conv(16'h0100, 16'h0000, 1'b0);
        chk("lft_ld2", {4'd0, lft_ld}, 16'h0100);
        chk("rider_1ff", {15'd0, rider_present}, 16'd0);
        conv(16'h0100, 16'h2000, 1'b0);
        chk("rider_200", {15'd0, rider_present}, 16'd1);
        conv(16'h0555, 16'h2800, 1'b0);

        // Timeout on the left channel: done never arrives in WAIT1.
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        chk("tmo_cmd", cmd, 16'h0000);
        n = 0;
        for (int i = 1; i <= 2 * TIMEOUT; i++) begin
            tick();
            if (err) begin
                n = i;
                break;
            end
        end
        chk("tmo_cycles", 16'(n), 16'(TIMEOUT + 1));
        chk("tmo_busy", {15'd0, busy}, 16'd0);
        chk("tmo_lft", {4'd0, lft_ld}, 16'h0100);
        chk("tmo_vld", {15'd0, vld}, 16'd0);
        tick();
        chk("err_width", {15'd0, err}, 16'd0);

        conv(16'h0123, 16'h2000, 1'b1);
        chk("poke_rght", {4'd0, rght_ld}, 16'h0123);
        chk("rider_223", {15'd0, rider_present}, 16'd1);

        // Abort a battery conversion from WAIT2.
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        chk("abort_cmd", cmd, 16'h2800);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk("abort_in_wait2", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        conv(16'h0042, 16'h0000, 1'b0);
        chk("post_rst_lft", {4'd0, lft_ld}, 16'h0042);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
